// File: rtl/slt_iter_cmp.sv
// Multi-cycle SLT/SLTU unit: compares CHUNK bits per cycle, MSB chunk first, valid/ready on both sides.
// Optional feature macro: SLT_EARLY_EXIT_EN (leave BUSY on the first deciding chunk).
module slt_iter_cmp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("slt_iter_cmp: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic             lt_q;
    logic             dec_q;
    logic [WIDTH-1:0] z_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [CHUNK-1:0] ca_c;
    logic [CHUNK-1:0] cb_c;
    logic             lt_d;
    logic             dec_d;
    logic             last_c;
    logic             finish_c;

    // Current chunk compare; once decided, lt is frozen for the remaining chunks.
    always_comb begin
        ca_c   = CHUNK'(a_q >> (32'(idx_q) * CHUNK));
        cb_c   = CHUNK'(b_q >> (32'(idx_q) * CHUNK));
        last_c = (idx_q == '0);
        lt_d   = lt_q;
        dec_d  = dec_q;
        if (!dec_q) begin
            if (ca_c < cb_c) begin
                lt_d  = 1'b1;
                dec_d = 1'b1;
            end else if (ca_c > cb_c) begin
                lt_d  = 1'b0;
                dec_d = 1'b1;
            end else if (last_c) begin
                lt_d  = 1'b0;
                dec_d = 1'b1;
            end
        end
`ifdef SLT_EARLY_EXIT_EN
        finish_c = dec_d || last_c;
`else
        finish_c = last_c;
`endif
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= IDX_TOP;
            lt_q        <= 1'b0;
            dec_q       <= 1'b0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        // Flipping the sign bit maps signed order onto unsigned order.
                        a_q        <= is_unsigned ? a : (a ^ MSB_MASK);
                        b_q        <= is_unsigned ? b : (b ^ MSB_MASK);
                        idx_q      <= IDX_TOP;
                        lt_q       <= 1'b0;
                        dec_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    lt_q  <= lt_d;
                    dec_q <= dec_d;
                    if (finish_c) begin
                        z_q         <= WIDTH'(lt_d);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_slt_iter_cmp.sv
// Scoreboard bench for slt_iter_cmp: expected results/latencies queued at accept, checked at the output handshake.
module tb_slt_iter_cmp;

    localparam int WIDTH    = 32;
    localparam int CHUNK    = 8;
    localparam int NCHUNK   = WIDTH / CHUNK;
    localparam int MAX_WAIT = 20;
`ifdef SLT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [31:0] z;
        int          lat;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_unsigned;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    slt_iter_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .is_unsigned (is_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .z           (z),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Edges from accept to out_valid: position of first differing chunk (early exit) or NCHUNK.
    function automatic int exp_lat(input logic [31:0] va, input logic [31:0] vb);
        int first;
        first = NCHUNK;
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (first == NCHUNK && va[i*CHUNK +: CHUNK] != vb[i*CHUNK +: CHUNK])
                first = NCHUNK - i;
        end
        return EARLY ? first : NCHUNK;
    endfunction

    function automatic logic [31:0] exp_z(input logic [31:0] va, input logic [31:0] vb, input logic u);
        logic lt;
        lt = u ? (va < vb) : ($signed(va) < $signed(vb));
        return {31'd0, lt};
    endfunction

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic u, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk);
        a           = va;
        b           = vb;
        is_unsigned = u;
        in_valid    = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        e.z   = exp_z(va, vb, u);
        e.lat = exp_lat(va, vb);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        a           = $urandom;
        b           = $urandom;
        is_unsigned = ~u;
        check("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(e.lat));
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_z", z, e.z);
                check("hold_in_ready", 32'(in_ready), 32'd0);
                in_valid    = 1'b1;
                a           = $urandom;
                b           = $urandom;
                is_unsigned = 1'($urandom);
                @(posedge clk);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = sb.pop_front();
        check("out_valid", 32'(out_valid), 32'd1);
        check("z", z, e.z);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        is_unsigned = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_z", z, 32'd0);
        rst_n = 1'b1;

        // Sign handling and signed overflow corners
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
        // Equal operands walk every chunk in both modes
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
        // Backpressure in DONE
        run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1);
        // Top-chunk decision; leaves z=1 before the reset test
        run_op(32'h0100_0000, 32'h0200_0000, 1'b1, 1'b0);

        // Reset in the second BUSY cycle abandons the operation
        @(negedge clk);
        a           = 32'h1234_5678;
        b           = 32'h1234_5678;
        is_unsigned = 1'b1;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_z", z, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("after_rst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 1'b0);

        // Random operands, many differing only in one chunk
        for (int k = 0; k < 16; k++) begin
            ra = $urandom;
            if (k % 3 == 0)
                rb = $urandom;
            else
                rb = ra ^ (32'($urandom_range(1, 255)) << (CHUNK * $urandom_range(0, NCHUNK - 1)));
            run_op(ra, rb, 1'($urandom_range(0, 1)), (k % 5) == 4);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slt_iter_cmp.md
# slt_iter_cmp

Parametrised, multi-cycle set-less-than unit for the ALU compare path. It computes SLT (signed) or SLTU (unsigned) on WIDTH-bit operands by comparing CHUNK bits per cycle, most significant chunk first. Result is {WIDTH-1 zeros, lt}. Operands enter and results leave over valid/ready handshakes, so the unit can sit behind the operand-read stage and feed writeback.

## Interface
- WIDTH, 32: operand and result width.
- CHUNK, 8: bits compared per cycle. WIDTH % CHUNK != 0 is an elaboration error. NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_unsigned  in  1  1 = SLTU, 0 = SLT; sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- z  out  WIDTH  result {WIDTH-1'b0, lt}.
- busy  out  1  high in BUSY or DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b and is_unsigned, set idx=NCHUNK-1, clear the decided flag, and go to BUSY.
- Signed mode: invert bit WIDTH-1 of both captured operands. All chunk compares are then unsigned. The result is a true signed compare with no subtraction overflow error.
- BUSY, each cycle, compares chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK):
  - A<B: lt=1, decided.
  - A>B: lt=0, decided.
  - Equal: if idx==0, lt=0, decided. Otherwise idx decrements.
- After the first decision, later chunks never change lt.
- Go from BUSY to DONE on the decision (early exit) or after chunk 0 (see Configuration). On that transition, z loads {0, lt}.
- DONE: out_valid=1. z and out_valid hold stable until out_ready. On out_valid&&out_ready, go to IDLE.
- No overlap: a new operand is accepted no earlier than the cycle after the result handshake.
- Inputs a, b and is_unsigned are ignored while in_ready=0.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, out_valid=0, z=0, busy=0, in_ready=1, idx=NCHUNK-1, lt=0.
- Let T be the accept edge. Chunk NCHUNK-1 is compared in the cycle after T.
- out_valid rises n edges after T:
  - With early exit, n = the position (1-based, MSB first) of the first differing chunk, or NCHUNK if all chunks are equal. Minimum 1, maximum NCHUNK.
  - Without early exit, n = NCHUNK always.
- CHUNK==WIDTH gives fixed single-cycle latency.
- Result handshake at edge U: out_valid=0 and in_ready=1 after U. The earliest next accept is edge U+1.
- Reset mid-operation: the operation is abandoned, no out_valid is produced, and all outputs take their reset values immediately.

## Configuration
- SLT_EARLY_EXIT_EN defined: BUSY exits on the first decision, giving data-dependent latency.
- SLT_EARLY_EXIT_EN undefined: BUSY always walks all NCHUNK chunks, giving fixed latency. The lt value is identical in both builds.

## Test plan
- Sign handling (default params): a=0xFFFFFFFF, b=0x00000001. With is_unsigned=0, z=0x00000001. With is_unsigned=1, z=0x00000000.
- Overflow corner, signed: a=0x80000000, b=0x00000001 gives z=1. a=0x7FFFFFFF, b=0x80000000 gives z=0.
- Latency, unsigned: a=0x01000000, b=0x02000000 gives z=1.
  - With SLT_EARLY_EXIT_EN, out_valid is high 1 edge after accept.
  - Without it, out_valid is high 4 edges after accept.
- Equal operands, a=b=0x12345678 in both modes: z=0 with out_valid 4 edges after accept in both builds.
- Backpressure: hold out_ready=0 for 3 cycles in DONE. z and out_valid stay stable, in_ready=0, and in_valid pulses are ignored. Releasing out_ready gives in_ready=1 the next cycle.
- Reset mid-op: assert rst_n=0 in the 2nd BUSY cycle. Outputs reset immediately and no out_valid appears. A fresh compare after release is correct.
